mem_stage: RTL
==============

Name: mem_stage

Overview:
- MEM pipeline stage of the 5-stage LoongArch CPU, between EX and WB.
- Latches the EX payload and waits for the data-SRAM load response. Aligns and extends load data into the final result.
- Forwards CSR/exception/ertn fields to WB unchanged.
- Supplies forwarding/blocking info to ID and a cancel indication to EX.

Parameters:
- EX_BUS_W, 194, width of EX_to_MEM_bus
- WB_BUS_W, 188, width of MEM_to_WB_bus

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- EX_to_MEM_valid  in  1  EX payload valid
- EX_to_MEM_bus  in  EX_BUS_W  {csr_we1, csr_num14, csr_wmask32, csr_wvalue32, inst_ertn1, ex_type6, res_from_mem1, ld_op5 (b,h,w,bu,hu one-hot, [4]=b), gr_we1, dest5, alu_result32, pc32, inst32}
- MEM_allow_in  out  1  stage can accept EX payload
- data_sram_data_ok  in  1  load/store response strobe
- data_sram_rdata  in  32  load data, valid with data_ok
- WB_allow_in  in  1  WB can accept
- MEM_to_WB_valid  out  1  payload valid to WB
- MEM_to_WB_bus  out  WB_BUS_W  {csr_we, csr_num, csr_wmask, csr_wvalue, inst_ertn, ex_type, final_result32, gr_we, dest, pc, inst}
- MEM_to_ID_bus  out  39  {fwd_we1, dest5, final_result32, ld_pending1}
- wb_flush  in  1  WB exception or ertn flush
- MEM_ex  out  1  MEM_valid & (|ex_type | inst_ertn): EX must suppress its store

Behaviour:
- Reset (async, resetn=0):
  - MEM_valid=0, rdata_buf_valid=0, bus register cleared to 0.
  - All outputs derived: MEM_to_WB_valid=0, MEM_ex=0, fwd_we=0, ld_pending=0.
- Accept: on the posedge where EX_to_MEM_valid & MEM_allow_in, latch the bus.
  - MEM_valid update priority: wb_flush → 0; else if MEM_allow_in → EX_to_MEM_valid.
  - wb_flush wins over a simultaneous accept.
- need_data = res_from_mem & ~|ex_type.
  - Stores complete in EX; this stage never waits on them.
- Load data buffer:
  - rdata_buf captures data_sram_rdata when MEM_valid & need_data & data_sram_data_ok & ~rdata_buf_valid.
  - Sets rdata_buf_valid=1 only if ~(MEM_to_WB_valid & WB_allow_in).
  - Cleared when the instruction leaves (MEM_to_WB_valid & WB_allow_in) or on wb_flush.
- MEM_ready_go = ~need_data | data_sram_data_ok | rdata_buf_valid.
  - Load with data_ok in the same cycle as entry completes with 0 added cycles.
- MEM_allow_in = ~MEM_valid | (MEM_ready_go & WB_allow_in).
- MEM_to_WB_valid = MEM_valid & MEM_ready_go & ~wb_flush.
- Load select: raw = rdata_buf_valid ? rdata_buf : data_sram_rdata; shifted = raw >> (8*alu_result[1:0]).
  - ld_b: sign-extend shifted[7:0]; ld_bu: zero-extend.
  - ld_h: sign-extend shifted[15:0]; ld_hu: zero-extend.
  - ld_w: raw.
  - Misaligned addresses are flagged upstream; here offset bit0 is ignored for halfword, offsets ignored for word.
- final_result = need_data ? load_value : alu_result.
- Exception passthrough:
  - ex_type and inst_ertn are forwarded unchanged.
  - A load with nonzero ex_type forwards alu_result and does not wait.
- Forwarding to ID:
  - fwd_we = MEM_valid & gr_we & (dest!=0).
  - ld_pending = MEM_valid & need_data & ~MEM_ready_go; ID must stall on a match while ld_pending=1.
- Stall hold: while MEM_valid & ~MEM_allow_in, the bus register and rdata_buf are stable.
- Reset mid-load: everything is cleared; a late data_ok after reset with MEM_valid=0 is ignored.

Test Plan:
1. ld_w, addr 0x1004, data_ok in the entry cycle with rdata=0x8899AABB → WB gets final_result=0x8899AABB the next posedge, no bubble.
2. ld_b, addr low bits 2'b11, rdata=0x80123456, data_ok 3 cycles late:
   - ld_pending=1 and MEM_allow_in=0 for 3 cycles.
   - final_result=0xFFFFFF80; the ld_bu variant gives 0x00000080.
3. ld_hu, addr low bits 2'b10, rdata=0xBEEF1234, data_ok while WB_allow_in=0 for 2 cycles → buffered; final_result=0x0000BEEF delivered once WB_allow_in=1.
4. add (res_from_mem=0), alu_result=0x5, dest=4, back-to-back with another add → one instruction per cycle to WB; MEM_to_ID_bus shows fwd_we=1, dest=4, result=5.
5. Syscall (ex_type=6'h01) followed by a valid EX instruction while wb_flush=1 → MEM_ex=1 for the syscall; MEM_valid=0 after the flush edge; the younger instruction is not latched as valid.
6. resetn deasserted asynchronously mid-stall → MEM_to_WB_valid and MEM_ex go 0 immediately; rdata_buf_valid=0.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the 5-stage LoongArch pipeline. It holds the EX payload, waits for the load response, then aligns and extends the load data.
// Latency: 1 cycle from accept to WB when data_ok arrives in the entry cycle (or for non-loads); a late load holds until data_ok arrives.
// Backpressure: MEM_allow_in drops while a load waits for data or WB refuses. A response that arrives during a WB stall is kept in rdata_buf.
// Ports: EX handshake (EX_to_MEM_valid/bus, MEM_allow_in), data SRAM response (data_ok/rdata),
//        WB handshake (MEM_to_WB_valid/bus, WB_allow_in), MEM_to_ID_bus forwarding, wb_flush in, MEM_ex out.
module mem_stage #(
    parameter int EX_BUS_W = 194,
    parameter int WB_BUS_W = 188
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                EX_to_MEM_valid,
    input  logic [EX_BUS_W-1:0] EX_to_MEM_bus,
    output logic                MEM_allow_in,
    input  logic                data_sram_data_ok,
    input  logic [31:0]         data_sram_rdata,
    input  logic                WB_allow_in,
    output logic                MEM_to_WB_valid,
    output logic [WB_BUS_W-1:0] MEM_to_WB_bus,
    output logic [38:0]         MEM_to_ID_bus,
    input  logic                wb_flush,
    output logic                MEM_ex
);

    logic                mem_valid;
    logic [EX_BUS_W-1:0] bus_q;
    logic [31:0]         rdata_buf;
    logic                rdata_buf_valid;

    // Fields of the latched EX payload
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        inst_ertn;
    logic [5:0]  ex_type;
    logic        res_from_mem;
    logic [4:0]  ld_op;        // one-hot {b, h, w, bu, hu}
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
    logic [31:0] inst;

    assign {csr_we, csr_num, csr_wmask, csr_wvalue, inst_ertn, ex_type, res_from_mem,
            ld_op, gr_we, dest, alu_result, pc, inst} = bus_q;

    logic        need_data;
    logic        ready_go;
    logic        leave;
    logic        capture;
    logic [31:0] raw;
    logic [31:0] shift_b;
    logic [31:0] shift_h;
    logic [31:0] load_value;
    logic [31:0] final_result;
    logic        fwd_we;
    logic        ld_pending;

    // A faulting load never went to memory, so it must not wait for a response.
    assign need_data       = res_from_mem & ~|ex_type;
    assign ready_go        = ~need_data | data_sram_data_ok | rdata_buf_valid;
    assign MEM_allow_in    = ~mem_valid | (ready_go & WB_allow_in);
    assign MEM_to_WB_valid = mem_valid & ready_go & ~wb_flush;
    assign leave           = MEM_to_WB_valid & WB_allow_in;
    assign capture         = mem_valid & need_data & data_sram_data_ok & ~rdata_buf_valid;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_valid <= 1'b0;
        end else if (wb_flush) begin
            mem_valid <= 1'b0;
        end else if (MEM_allow_in) begin
            mem_valid <= EX_to_MEM_valid;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus_q <= '0;
        end else if (EX_to_MEM_valid && MEM_allow_in) begin
            bus_q <= EX_to_MEM_bus;
        end
    end

    // The SRAM presents rdata for one cycle only. Keep it if WB cannot take the result in that cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_buf       <= 32'h0;
            rdata_buf_valid <= 1'b0;
        end else if (wb_flush || leave) begin
            rdata_buf_valid <= 1'b0;
        end else if (capture) begin
            rdata_buf       <= data_sram_rdata;
            rdata_buf_valid <= 1'b1;
        end
    end

    // Align by address offset. Halfword ignores offset bit 0 and word ignores the offset; misalignment is trapped upstream.
    assign raw     = rdata_buf_valid ? rdata_buf : data_sram_rdata;
    assign shift_b = raw >> {alu_result[1:0], 3'b000};
    assign shift_h = raw >> {alu_result[1], 4'b0000};

    always_comb begin
        load_value = raw;
        if (ld_op[4]) begin
            load_value = {{24{shift_b[7]}}, shift_b[7:0]};
        end else if (ld_op[3]) begin
            load_value = {{16{shift_h[15]}}, shift_h[15:0]};
        end else if (ld_op[1]) begin
            load_value = {24'h0, shift_b[7:0]};
        end else if (ld_op[0]) begin
            load_value = {16'h0, shift_h[15:0]};
        end
    end

    assign final_result = need_data ? load_value : alu_result;
    assign fwd_we       = mem_valid & gr_we & (dest != 5'd0);
    assign ld_pending   = mem_valid & need_data & ~ready_go;
    assign MEM_ex       = mem_valid & (|ex_type | inst_ertn);

    assign MEM_to_WB_bus = {csr_we, csr_num, csr_wmask, csr_wvalue, inst_ertn, ex_type,
                            final_result, gr_we, dest, pc, inst};
    assign MEM_to_ID_bus = {fwd_we, dest, final_result, ld_pending};

endmodule
